// File: rtl/apb_gpio_slave.sv
// APB completer for a GPIO bank: DOUT/DIR/DIN/IEN/ISTAT registers with optional
// wait states, error signalling, input synchronisation and rising-edge interrupt.
module apb_gpio_slave #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int STRB_WIDTH    = 4,
  parameter int GPIO_WIDTH    = 8,
  parameter int WAIT_STATES   = 0
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [ADDRESS_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0]    PWDATA,
  input  logic [STRB_WIDTH-1:0]    PSTRB,
  output logic [DATA_WIDTH-1:0]    PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  input  logic [GPIO_WIDTH-1:0]    GPIO_IN,
  output logic [GPIO_WIDTH-1:0]    GPIO_OUT,
  output logic [GPIO_WIDTH-1:0]    GPIO_OE,
  output logic                     IRQ
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [4:0] OFF_DOUT  = 5'h00;
  localparam logic [4:0] OFF_DIR   = 5'h04;
  localparam logic [4:0] OFF_DIN   = 5'h08;
  localparam logic [4:0] OFF_IEN   = 5'h0C;
  localparam logic [4:0] OFF_ISTAT = 5'h10;

  logic [1:0]            phase;
  logic [3:0]            cnt;
  logic                  access;
  logic                  err;
  logic                  wr_en;
  logic [4:0]            off;
  logic [GPIO_WIDTH-1:0] wmask;
  logic [GPIO_WIDTH-1:0] wdata;
  logic [GPIO_WIDTH-1:0] dout, dir, ien, istat, istat_nxt;
  logic [GPIO_WIDTH-1:0] sync1, din, din_d, rise, rsel;
  logic                  unused_bus_bits;

  assign unused_bus_bits = ^{PADDR, PWDATA, PSTRB};

  always_comb begin
    phase = ST_IDLE;
    if (PSEL) phase = PENABLE ? ST_ACCESS : ST_SETUP;
  end

  assign access = (phase == ST_ACCESS);
  assign off    = PADDR[4:0];
  assign err    = (off > OFF_ISTAT) || (off[1:0] != 2'b00) || (PWRITE && off == OFF_DIN);
  assign PREADY = access && (cnt == WS);
  assign wr_en  = PREADY && PWRITE && !err;
  assign wdata  = PWDATA[GPIO_WIDTH-1:0];

  // Byte strobe for lane i/8 gates each register bit i.
  always_comb begin
    wmask = '0;
    for (int unsigned i = 0; i < GPIO_WIDTH; i++) wmask[i] = PSTRB[i/8];
  end

  assign rise = din & ~din_d & ien;

  // Clear first, then OR in new edges so a simultaneous rise keeps the bit set.
  always_comb begin
    istat_nxt = istat;
    if (wr_en && off == OFF_ISTAT) istat_nxt = istat & ~(wdata & wmask);
    istat_nxt = istat_nxt | rise;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      cnt   <= '0;
      dout  <= '0;
      dir   <= '0;
      ien   <= '0;
      istat <= '0;
      sync1 <= '0;
      din   <= '0;
      din_d <= '0;
    end else begin
      if (!access)       cnt <= '0;
      else if (cnt < WS) cnt <= cnt + 4'd1;

      sync1 <= GPIO_IN;
      din   <= sync1;
      din_d <= din;

      if (wr_en && off == OFF_DOUT) dout <= (dout & ~wmask) | (wdata & wmask);
      if (wr_en && off == OFF_DIR)  dir  <= (dir  & ~wmask) | (wdata & wmask);
      if (wr_en && off == OFF_IEN)  ien  <= (ien  & ~wmask) | (wdata & wmask);
      istat <= istat_nxt;
    end
  end

  always_comb begin
    rsel = '0;
    case (off)
      OFF_DOUT:  rsel = dout;
      OFF_DIR:   rsel = dir;
      OFF_DIN:   rsel = din;
      OFF_IEN:   rsel = ien;
      OFF_ISTAT: rsel = istat;
      default:   rsel = '0;
    endcase
  end

  always_comb begin
    PRDATA = '0;
    if (PREADY && !PWRITE && !err) PRDATA[GPIO_WIDTH-1:0] = rsel;
  end

  assign PSLVERR  = PREADY && err;
  assign GPIO_OUT = dout;
  assign GPIO_OE  = dir;
  assign IRQ      = |istat;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed bench for apb_gpio_slave: a zero-wait and a two-wait instance on
// separate select lines, checked against a scoreboard of expected values.
module tb_apb_gpio_slave;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        presetn, psel0, psel1, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [7:0]  gpio_in;

  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1, irq0, irq1;
  logic [7:0]  gpio_out0, gpio_out1, gpio_oe0, gpio_oe1;

  logic        tsel;
  logic [31:0] cur_prdata;
  logic        cur_pready, cur_pslverr;
  logic [7:0]  cur_oe;

  assign cur_prdata  = tsel ? prdata1  : prdata0;
  assign cur_pready  = tsel ? pready1  : pready0;
  assign cur_pslverr = tsel ? pslverr1 : pslverr0;
  assign cur_oe      = tsel ? gpio_oe1 : gpio_oe0;

  apb_gpio_slave #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .STRB_WIDTH(4),
                   .GPIO_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0), .PREADY(pready0),
    .PSLVERR(pslverr0), .GPIO_IN(gpio_in), .GPIO_OUT(gpio_out0), .GPIO_OE(gpio_oe0),
    .IRQ(irq0));

  apb_gpio_slave #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .STRB_WIDTH(4),
                   .GPIO_WIDTH(8), .WAIT_STATES(2)) dut1 (
    .PCLK(clk), .PRESETn(presetn), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata1), .PREADY(pready1),
    .PSLVERR(pslverr1), .GPIO_IN(gpio_in), .GPIO_OUT(gpio_out1), .GPIO_OE(gpio_oe1),
    .IRQ(irq1));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [31:0] rd;
  logic        er;
  int          w;
  logic [7:0]  oe_r;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    expect_val(tag, exp);
    check_next(obs);
  endtask

  // One complete transfer; returns read data, error, wait count and OE seen at PREADY.
  task automatic apb(input logic sel, input logic wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] strb,
                     output logic [31:0] rdo, output logic erro, output int waits,
                     output logic [7:0] oe_at_ready);
    @(negedge clk);
    tsel = sel; psel0 = !sel; psel1 = sel; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    #1;
    chk("setup_pready", 32'(cur_pready), 32'd0);
    chk("setup_pslverr", 32'(cur_pslverr), 32'd0);
    @(negedge clk);
    penable = 1'b1;
    waits = 0;
    #1;
    while (!cur_pready && waits < 20) begin
      chk("wait_pslverr", 32'(cur_pslverr), 32'd0);
      @(negedge clk);
      #1;
      waits++;
    end
    if (!cur_pready) begin
      n_total++;
      $error("FAIL pready_timeout observed=0 expected=1");
    end
    rdo = cur_prdata;
    erro = cur_pslverr;
    oe_at_ready = cur_oe;
    @(negedge clk);
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  initial begin
    presetn = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; gpio_in = '0; tsel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pready0", 32'(pready0), 32'd0);
    chk("rst_pslverr0", 32'(pslverr0), 32'd0);
    chk("rst_prdata0", prdata0, 32'd0);
    chk("rst_gpio_out0", 32'(gpio_out0), 32'd0);
    chk("rst_gpio_oe1", 32'(gpio_oe1), 32'd0);
    chk("rst_irq0", 32'(irq0), 32'd0);
    presetn = 1'b1;

    // Zero-wait write then read
    apb(1'b0, 1'b1, 32'h00, 32'h0000_00A5, 4'hF, rd, er, w, oe_r);
    chk("ws0_write_waits", 32'(w), 32'd0);
    chk("ws0_write_err", 32'(er), 32'd0);
    chk("ws0_gpio_out", 32'(gpio_out0), 32'h0000_00A5);
    apb(1'b0, 1'b0, 32'h00, 32'h0, 4'h0, rd, er, w, oe_r);
    chk("ws0_read_data", rd, 32'h0000_00A5);
    chk("ws0_read_err", 32'(er), 32'd0);

    // Two wait states on the DIR write
    apb(1'b1, 1'b1, 32'h04, 32'h0000_00FF, 4'hF, rd, er, w, oe_r);
    chk("ws2_waits", 32'(w), 32'd2);
    chk("ws2_oe_before_edge", 32'(oe_r), 32'd0);
    chk("ws2_oe_after_edge", 32'(gpio_oe1), 32'h0000_00FF);

    // Byte strobes
    apb(1'b0, 1'b1, 32'h00, 32'h0, 4'hF, rd, er, w, oe_r);
    chk("strb_clear", 32'(gpio_out0), 32'd0);
    apb(1'b0, 1'b1, 32'h00, 32'hFFFF_FF3C, 4'b0001, rd, er, w, oe_r);
    chk("strb_lane0", 32'(gpio_out0), 32'h0000_003C);
    apb(1'b0, 1'b1, 32'h00, 32'hFFFF_FF55, 4'b0000, rd, er, w, oe_r);
    chk("strb_none", 32'(gpio_out0), 32'h0000_003C);

    // Interrupt path: three edges from pin to IRQ
    apb(1'b0, 1'b1, 32'h0C, 32'h0000_0001, 4'hF, rd, er, w, oe_r);
    gpio_in = 8'h01;
    @(negedge clk);
    chk("irq_edge1", 32'(irq0), 32'd0);
    @(negedge clk);
    chk("irq_edge2", 32'(irq0), 32'd0);
    @(negedge clk);
    chk("irq_edge3", 32'(irq0), 32'd1);
    chk("irq_ien_off_dut1", 32'(irq1), 32'd0);
    apb(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, w, oe_r);
    chk("istat_read", rd, 32'h0000_0001);
    apb(1'b0, 1'b1, 32'h10, 32'h0000_0001, 4'hF, rd, er, w, oe_r);
    chk("istat_w1c_irq", 32'(irq0), 32'd0);
    gpio_in = 8'h03;
    repeat (4) @(negedge clk);
    chk("irq_masked_pin1", 32'(irq0), 32'd0);
    apb(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, w, oe_r);
    chk("istat_after_masked", rd, 32'd0);

    // Error cases
    apb(1'b0, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, w, oe_r);
    chk("err_oob_flag", 32'(er), 32'd1);
    chk("err_oob_data", rd, 32'd0);
    apb(1'b0, 1'b1, 32'h08, 32'h0000_0000, 4'hF, rd, er, w, oe_r);
    chk("err_din_write_flag", 32'(er), 32'd1);
    apb(1'b0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, w, oe_r);
    chk("din_unchanged", rd, 32'h0000_0003);
    chk("din_read_err", 32'(er), 32'd0);
    apb(1'b0, 1'b0, 32'h02, 32'h0, 4'h0, rd, er, w, oe_r);
    chk("err_unaligned_flag", 32'(er), 32'd1);
    chk("err_unaligned_data", rd, 32'd0);
    apb(1'b0, 1'b1, 32'h14, 32'h0000_00FF, 4'hF, rd, er, w, oe_r);
    chk("err_oob_write_flag", 32'(er), 32'd1);
    chk("err_oob_write_dout", 32'(gpio_out0), 32'h0000_003C);

    // Reset during the second wait cycle of a DOUT write
    apb(1'b1, 1'b1, 32'h00, 32'h0000_005A, 4'hF, rd, er, w, oe_r);
    chk("pre_rst_dout1", 32'(gpio_out1), 32'h0000_005A);
    @(negedge clk);
    tsel = 1'b1; psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h00; pwdata = 32'h0000_00FF; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    presetn = 1'b0;
    @(negedge clk);
    chk("midrst_gpio_out1", 32'(gpio_out1), 32'd0);
    chk("midrst_pready1", 32'(pready1), 32'd0);
    chk("midrst_pslverr1", 32'(pslverr1), 32'd0);
    chk("midrst_prdata1", prdata1, 32'd0);
    chk("midrst_gpio_oe1", 32'(gpio_oe1), 32'd0);
    chk("midrst_gpio_out0", 32'(gpio_out0), 32'd0);
    presetn = 1'b1; psel1 = 1'b0; penable = 1'b0;
    apb(1'b1, 1'b1, 32'h00, 32'h0000_0011, 4'hF, rd, er, w, oe_r);
    chk("postrst_waits", 32'(w), 32'd2);
    chk("postrst_gpio_out1", 32'(gpio_out1), 32'h0000_0011);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_gpio_slave.md
# apb_gpio_slave

APB completer driving a bank of general-purpose I/O pins; it sits directly downstream of the APB master and is attached to one of the master's slave-select lines (PSEL1 or PSEL2). It decodes setup and access phases and inserts a configurable number of wait states via PREADY. It flags illegal accesses on PSLVERR and returns read data on PRDATA. It also synchronises input pins and raises a level interrupt on enabled rising edges.

## Interface
- DATA_WIDTH, 32, APB data bus width
- ADDRESS_WIDTH, 32, APB address width
- STRB_WIDTH, 4, write byte-strobe width (DATA_WIDTH/8)
- GPIO_WIDTH, 8, number of pins (1..32); register bits at and above GPIO_WIDTH read 0, writes ignored
- WAIT_STATES, 0, PREADY-low cycles inserted in every access phase (0..15)

- PCLK  in  1  clock; all state updates on rising edge
- PRESETn  in  1  reset: synchronous, active-low
- PSEL  in  1  slave select from master
- PENABLE  in  1  access-phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDRESS_WIDTH  byte address; only PADDR[4:0] decoded
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  STRB_WIDTH  write byte enables
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer completion
- PSLVERR  out  1  transfer error, valid only with PREADY
- GPIO_IN  in  GPIO_WIDTH  asynchronous pin inputs
- GPIO_OUT  out  GPIO_WIDTH  pin output values
- GPIO_OE  out  GPIO_WIDTH  pin output enables (1 = drive)
- IRQ  out  1  interrupt, level

## Operation
- Register map (offset = PADDR[4:0]):
  - 0x00 DOUT, RW
  - 0x04 DIR, RW, 1 = output
  - 0x08 DIN, RO, synchronised pins
  - 0x0C IEN, RW
  - 0x10 ISTAT, RW1C
- Error conditions (PSLVERR=1): offset > 0x10; PADDR[1:0] != 0; write to DIN. An erroring write changes no register; an erroring read returns PRDATA=0.
- Protocol states, derived from inputs plus a wait counter `cnt` (4 bits):
  - IDLE: PSEL=0.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- `cnt` behaviour:
  - Cleared to 0 whenever not in ACCESS.
  - In ACCESS with cnt < WAIT_STATES, increments each cycle.
- PREADY = ACCESS && cnt == WAIT_STATES (combinational). Transfer completes on the PCLK edge where PREADY=1.
- Writes commit at the completing edge. Each byte lane i is updated only if PSTRB[i]=1. For ISTAT, a 1 in an enabled lane clears the bit.
- PRDATA = selected register when ACCESS && PREADY && !PWRITE && no error; otherwise 0.
- PSLVERR = ACCESS && PREADY && error; otherwise 0.
- GPIO_OUT = DOUT, GPIO_OE = DIR.
- Input path: GPIO_IN passes through a 2-flop synchroniser into DIN, then one further register `din_d` for edge detection.
- rise = DIN & ~din_d & IEN. ISTAT |= rise every cycle.
- Same-cycle rise and RW1C on the same bit: set wins (bit stays 1).
- IRQ = |ISTAT (combinational from registered ISTAT).

## Timing
- Reset (PRESETn=0 at a PCLK edge): DOUT, DIR, IEN, ISTAT, synchroniser flops, din_d and cnt all go to 0. Consequently PREADY=0, PSLVERR=0, PRDATA=0, GPIO_OUT=0, GPIO_OE=0, IRQ=0.
- Reset asserted mid-access wins: any pending write is discarded and cnt returns to 0.
- WAIT_STATES=0: PREADY is high in the first ACCESS cycle. The transfer takes 2 cycles (setup + access).
- WAIT_STATES=N: PREADY is low for N ACCESS cycles and high on cycle N+1. The transfer takes N+2 cycles.
- Back-to-back transfers (master goes SETUP straight after completion): cnt is 0 in SETUP, so each transfer has identical latency.
- PSEL or PENABLE dropping during wait cycles aborts the transfer: cnt is cleared and no register is written.
- Pin to DIN latency: 2 edges. Pin to ISTAT/IRQ latency: 3 edges.
- DIN reflects pins regardless of DIR.

## Test plan
- Zero-wait write then read, WAIT_STATES=0:
  - Write 0x0000_00A5 to 0x00, PSTRB=0xF -> PREADY=1 in first access cycle, GPIO_OUT=0xA5 after the edge.
  - Read 0x00 -> PRDATA=0xA5, PSLVERR=0.
- Wait states, WAIT_STATES=2: write DIR=0xFF -> PREADY low for exactly 2 access cycles, high on the 3rd, GPIO_OE=0xFF only after that edge.
- Byte strobes: DOUT=0x00, write 0xFFFF_FF3C with PSTRB=0b0001 -> DOUT=0x3C; repeat with PSTRB=0b0000 -> DOUT stays 0x3C.
- Errors:
  - Read 0x14 -> PSLVERR=1, PRDATA=0.
  - Write 0x08 -> PSLVERR=1, DIN unchanged.
  - Address 0x02 -> PSLVERR=1.
  - Outside PREADY, PSLVERR=0.
- Interrupt:
  - IEN=0x01, GPIO_IN[0] 0->1 -> ISTAT=0x01 and IRQ=1 three edges later.
  - Write 0x01 to 0x10 -> IRQ=0.
  - Rising edge on GPIO_IN[1] with IEN[1]=0 -> IRQ stays 0.
- Reset mid-operation: PRESETn=0 during the 2nd wait cycle of a write to DOUT -> DOUT=0, PREADY=0 and all outputs 0 after the edge; next transfer has full latency.
